enc16x4_seq: RTL and testbench



---
 rtl/enc16x4_seq.sv | 129 ++++++++++++
 tb/tb_enc16x4_seq.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/enc16x4_seq.sv
// Sequential 16->4 priority encoder: emits the index of every set bit of a captured vector, lowest first.
// Latency: first index valid one cycle after an accepted load; then one index per cycle; DONE lasts one cycle.
// Backpressure: out_ready low in SCAN freezes mask/out/remaining indefinitely; load is ignored while busy.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in[15:0]   request vector, captured only on an accepted load (IDLE && load)
//   load       start request
//   out_ready  consumer accepts the current index this cycle
//   out[3:0]   index of the lowest pending set bit (0 when nothing is pending)
//   out_valid  high exactly in SCAN
//   busy       high in SCAN and DONE
//   remaining  number of set bits still pending, 0..16
//   done       one-cycle end-of-job pulse (the DONE state)
//   none       coincident with done when the captured vector was all zeros

module enc16x4_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in,
  input  logic        load,
  input  logic        out_ready,
  output logic [3:0]  out,
  output logic        out_valid,
  output logic        busy,
  output logic [4:0]  remaining,
  output logic        done,
  output logic        none
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] mask, mask_nxt;
  logic [4:0]  rem_q, rem_nxt;
  logic        none_q, none_nxt;
  logic [3:0]  low_idx;
  logic [4:0]  in_cnt;

  // Index of the lowest set bit; bit 0 wins. All-zero input maps to 0.
  function automatic logic [3:0] lowest_idx(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Number of set bits; 5 bits so that 16'hFFFF counts to 16 without wrapping.
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + 5'(v[i]);
    end
    return cnt;
  endfunction

  assign low_idx = lowest_idx(mask);
  assign in_cnt  = popcount16(in);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      mask   <= 16'd0;
      rem_q  <= 5'd0;
      none_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      mask   <= mask_nxt;
      rem_q  <= rem_nxt;
      none_q <= none_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    mask_nxt  = mask;
    rem_nxt   = rem_q;
    none_nxt  = none_q;
    unique case (state)
      IDLE: begin
        if (load) begin
          mask_nxt  = in;
          rem_nxt   = in_cnt;
          none_nxt  = (in == 16'd0);
          state_nxt = (in == 16'd0) ? DONE : SCAN;
        end
      end
      SCAN: begin
        // out_valid is implied by being in SCAN, so out_ready alone qualifies a transfer.
        if (out_ready) begin
          // Clearing the lowest set bit is the same as clearing mask[out].
          mask_nxt = mask & (mask - 16'd1);
          if (rem_q != 5'd0) rem_nxt = rem_q - 5'd1;
          if (rem_q <= 5'd1) state_nxt = DONE;
        end
      end
      DONE: begin
        // load is deliberately not looked at here: a job cannot start in its own DONE cycle.
        none_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        mask_nxt  = 16'd0;
        rem_nxt   = 5'd0;
        none_nxt  = 1'b0;
      end
    endcase
  end

  // Outputs depend on registered state only.
  assign out       = low_idx;
  assign out_valid = (state == SCAN);
  assign busy      = (state != IDLE);
  assign remaining = rem_q;
  assign done      = (state == DONE);
  assign none      = (state == DONE) && none_q;

endmodule

// File: tb/tb_enc16x4_seq.sv
// Self-checking bench for enc16x4_seq.
// Expected indices are queued when a vector is loaded and popped as the DUT hands them over.
// Inputs change 1 time unit after the rising edge; outputs are read there or on the falling edge.

module tb_enc16x4_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in;
  logic        load;
  logic        out_ready;
  logic [3:0]  out;
  logic        out_valid;
  logic        busy;
  logic [4:0]  remaining;
  logic        done;
  logic        none;

  enc16x4_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .load      (load),
    .out_ready (out_ready),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy),
    .remaining (remaining),
    .done      (done),
    .none      (none)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] idx;
    logic [4:0] rem;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] pc16(input logic [15:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 16; i++) if (v[i]) c = c + 5'd1;
    return c;
  endfunction

  // Queue the expected index stream for a vector: ascending, with the count before each transfer.
  task automatic push_job(input logic [15:0] v);
    exp_t       e;
    logic [4:0] r;
    r = pc16(v);
    for (int i = 0; i < 16; i++) begin
      if (v[i]) begin
        e.idx = 4'(i);
        e.rem = r;
        exp_q.push_back(e);
        r = r - 5'd1;
      end
    end
  endtask

  // Load a vector; returns one time unit after the accepting edge.
  task automatic start(input logic [15:0] v);
    push_job(v);
    in   = v;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  // Transfer monitor: a handshake seen before the edge completes at that edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_extra_out", 32'(out), 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_idx", 32'(out), 32'(mon_e.idx));
        chk("sb_rem", 32'(remaining), 32'(mon_e.rem));
      end
    end
  end

  task automatic chk_idle(input string tag);
    chk({tag, "_out"},   32'(out),       0);
    chk({tag, "_vld"},   32'(out_valid), 0);
    chk({tag, "_busy"},  32'(busy),      0);
    chk({tag, "_rem"},   32'(remaining), 0);
    chk({tag, "_done"},  32'(done),      0);
    chk({tag, "_none"},  32'(none),      0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no end expected end before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] v;
    int          c;

    // Reset, with a load held during reset that must be ignored.
    rst = 1'b1; load = 1'b1; in = 16'hFFFF; out_ready = 1'b1;
    #2;
    chk_idle("rst");
    tick(); tick();
    chk_idle("rst_load");
    rst = 1'b0; load = 1'b0;
    tick();
    chk_idle("post_rst");

    // All-zero vector goes straight to DONE with none.
    start(16'h0000);
    chk("z_done", 32'(done), 1);
    chk("z_none", 32'(none), 1);
    chk("z_vld",  32'(out_valid), 0);
    chk("z_busy", 32'(busy), 1);
    tick();
    chk("z_busy2", 32'(busy), 0);
    chk("z_done2", 32'(done), 0);
    chk("z_none2", 32'(none), 0);

    // 16'h8421 at full throughput: 0,5,10,15 then done on cycle 5.
    out_ready = 1'b1;
    start(16'h8421);
    chk("a_out0", 32'(out), 0);
    chk("a_rem0", 32'(remaining), 4);
    chk("a_busy", 32'(busy), 1);
    for (int i = 0; i < 4; i++) tick();
    chk("a_done", 32'(done), 1);
    chk("a_none", 32'(none), 0);
    chk("a_vld",  32'(out_valid), 0);
    chk("a_drain", 32'(exp_q.size()), 0);
    tick();
    chk("a_idle", 32'(busy), 0);

    // 16'h0006 with a three-cycle stall.
    out_ready = 1'b0;
    start(16'h0006);
    for (int i = 0; i < 3; i++) begin
      chk("s_out", 32'(out), 1);
      chk("s_vld", 32'(out_valid), 1);
      chk("s_rem", 32'(remaining), 2);
      tick();
    end
    out_ready = 1'b1;
    chk("s_out_rdy", 32'(out), 1);
    tick();
    chk("s_out2", 32'(out), 2);
    chk("s_rem2", 32'(remaining), 1);
    tick();
    chk("s_done", 32'(done), 1);
    chk("s_drain", 32'(exp_q.size()), 0);
    tick();

    // 16'hFFFF: remaining starts at 16, done on cycle 17.
    out_ready = 1'b1;
    start(16'hFFFF);
    chk("f_rem16", 32'(remaining), 16);
    for (int i = 0; i < 15; i++) tick();
    chk("f_out15", 32'(out), 15);
    chk("f_rem1",  32'(remaining), 1);
    tick();
    chk("f_done", 32'(done), 1);
    chk("f_rem0", 32'(remaining), 0);
    chk("f_out0", 32'(out), 0);
    chk("f_drain", 32'(exp_q.size()), 0);
    tick();

    // Load during SCAN and during DONE is ignored.
    start(16'h0102);
    in = 16'h0001; load = 1'b1;
    chk("l_out0", 32'(out), 1);
    tick();
    chk("l_out1", 32'(out), 8);
    tick();
    chk("l_done", 32'(done), 1);
    tick();
    load = 1'b0;
    chk("l_idle_busy", 32'(busy), 0);
    chk("l_idle_rem",  32'(remaining), 0);
    chk("l_drain", 32'(exp_q.size()), 0);

    // Reset mid-SCAN between edges, then an immediate new job.
    out_ready = 1'b1;
    start(16'hF000);
    chk("r_out0", 32'(out), 12);
    tick();
    chk("r_out1", 32'(out), 13);
    chk("r_rem1", 32'(remaining), 3);
    #2 rst = 1'b1;
    #1;
    chk_idle("r_async");
    exp_q.delete();
    tick();
    chk("r_nodone", 32'(done), 0);
    chk("r_busy", 32'(busy), 0);
    rst = 1'b0;
    start(16'h0010);
    chk("r_new_out", 32'(out), 4);
    chk("r_new_vld", 32'(out_valid), 1);
    chk("r_new_rem", 32'(remaining), 1);
    tick();
    chk("r_new_done", 32'(done), 1);
    chk("r_drain", 32'(exp_q.size()), 0);
    tick();

    // Random vectors with random backpressure.
    for (int j = 0; j < 20; j++) begin
      v = 16'($urandom()) & 16'($urandom());
      if (j == 0) v = 16'h8000;
      out_ready = 1'($urandom_range(0, 1));
      start(v);
      chk("rnd_rem_first", 32'(remaining), 32'(pc16(v)));
      c = 0;
      while (!done && c < 60) begin
        out_ready = 1'($urandom_range(0, 1));
        tick();
        c++;
      end
      chk("rnd_done", 32'(done), 1);
      chk("rnd_none", 32'(none), 32'(v == 16'd0));
      chk("rnd_drain", 32'(exp_q.size()), 0);
      tick();
      chk("rnd_idle", 32'(busy), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
